// File: rtl/numeric_field_writer.sv
// Numeric readout writer: snapshots fields, converts each value to decimal by
// double-dabble, and streams ASCII digits/separators into the character RAM.
module numeric_field_writer #(
  parameter int unsigned NUM_FIELDS  = 4,
  parameter int unsigned VALUE_WIDTH = 17,
  parameter int unsigned MAX_DIGITS  = 6,
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 60,
  parameter int unsigned BASE_ROW    = 0,
  parameter int unsigned BASE_COL    = 2,
  parameter int unsigned TICK_PERIOD = 800000
) (
  input  logic                              clock50MHz,
  input  logic                              resetn,
  input  logic [NUM_FIELDS*VALUE_WIDTH-1:0] fieldValues,
  input  logic [NUM_FIELDS*3-1:0]           fieldDigits,
  input  logic [NUM_FIELDS*7-1:0]           fieldSep,
  input  logic                              suppressZeros,
  input  logic                              updateReq,
  output logic                              busy,
  output logic                              donePulse,
  output logic                              charRamWrEn,
  output logic [ADDR_WIDTH-1:0]             charRamAddr,
  output logic [6:0]                        charRamData
);

  localparam int unsigned FIELD_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned BIT_W     = $clog2(VALUE_WIDTH + 1);
  localparam int unsigned TICK_W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned TICK_LAST = (TICK_PERIOD > 0) ? TICK_PERIOD - 1 : 0;
  localparam int unsigned CELL_LAST = COLS * ROWS - 1;
  localparam int unsigned CURSOR0   = BASE_ROW * COLS + BASE_COL;
  localparam int unsigned BCD_W     = 4 * MAX_DIGITS;
  localparam int unsigned DD_W      = BCD_W + VALUE_WIDTH;

  typedef enum logic [2:0] {IDLE, LATCH, CONVERT, DIGITS, SEP, NEXT, DONE} state_t;

  state_t                  state;
  logic [TICK_W-1:0]       tickCount;
  logic                    pending;
  logic [VALUE_WIDTH-1:0]  valueSnap  [NUM_FIELDS];
  logic [2:0]              digitsSnap [NUM_FIELDS];
  logic [6:0]              sepSnap    [NUM_FIELDS];
  logic                    suppressSnap;
  logic [FIELD_W-1:0]      fieldIdx;
  logic [BIT_W-1:0]        bitCnt;
  logic [DD_W-1:0]         dd;
  logic [2:0]              digIdx;
  logic                    leadZero;
  logic [ADDR_WIDTH-1:0]   cursor;

  logic                    tickHit;
  logic                    trigger;
  logic [2:0]              nDigits;
  logic [6:0]              curSep;
  logic [3:0]              curDigit;
  logic                    blank;
  logic [ADDR_WIDTH-1:0]   nextCursor;
  logic [DD_W-1:0]         ddAdj;

  assign tickHit    = (TICK_PERIOD != 0) && (tickCount == TICK_W'(TICK_LAST));
  assign trigger    = updateReq | tickHit;
  assign nDigits    = (digitsSnap[fieldIdx] > 3'(MAX_DIGITS)) ? 3'(MAX_DIGITS) : digitsSnap[fieldIdx];
  assign curSep     = sepSnap[fieldIdx];
  assign curDigit   = dd[VALUE_WIDTH + 4*int'(digIdx) +: 4];
  assign blank      = suppressSnap && leadZero && (curDigit == 4'd0) && (digIdx != 3'd0);
  assign nextCursor = (cursor == ADDR_WIDTH'(CELL_LAST)) ? '0 : cursor + 1'b1;

  // Double-dabble add-3 correction; the shift happens on the register load.
  always_comb begin
    ddAdj = dd;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (dd[VALUE_WIDTH + 4*i +: 4] >= 4'd5)
        ddAdj[VALUE_WIDTH + 4*i +: 4] = dd[VALUE_WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (!resetn) begin
      state        <= IDLE;
      tickCount    <= '0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      donePulse    <= 1'b0;
      charRamWrEn  <= 1'b0;
      charRamAddr  <= '0;
      charRamData  <= '0;
      suppressSnap <= 1'b0;
      fieldIdx     <= '0;
      bitCnt       <= '0;
      dd           <= '0;
      digIdx       <= '0;
      leadZero     <= 1'b0;
      cursor       <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        valueSnap[i]  <= '0;
        digitsSnap[i] <= '0;
        sepSnap[i]    <= '0;
      end
    end else begin
      charRamWrEn <= 1'b0;
      donePulse   <= 1'b0;
      if (TICK_PERIOD != 0) tickCount <= tickHit ? '0 : tickCount + 1'b1;
      // Triggers arriving mid-pass collapse into one pending flag
      if (trigger && state != IDLE && state != DONE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            valueSnap[i]  <= fieldValues[i*VALUE_WIDTH +: VALUE_WIDTH];
            digitsSnap[i] <= fieldDigits[i*3 +: 3];
            sepSnap[i]    <= fieldSep[i*7 +: 7];
          end
          suppressSnap <= suppressZeros;
          fieldIdx     <= '0;
          cursor       <= ADDR_WIDTH'(CURSOR0);
          dd           <= {BCD_W'(0), fieldValues[VALUE_WIDTH-1:0]};
          bitCnt       <= '0;
          state        <= CONVERT;
        end
        CONVERT: begin
          dd     <= ddAdj << 1;
          bitCnt <= bitCnt + 1'b1;
          if (bitCnt == BIT_W'(VALUE_WIDTH - 1)) begin
            digIdx   <= nDigits - 3'd1;
            leadZero <= 1'b1;
            if (nDigits != 3'd0)     state <= DIGITS;
            else if (curSep != 7'd0) state <= SEP;
            else                     state <= NEXT;
          end
        end
        DIGITS: begin
          charRamWrEn <= 1'b1;
          charRamAddr <= cursor;
          charRamData <= blank ? 7'd32 : 7'd48 + 7'(curDigit);
          cursor      <= nextCursor;
          leadZero    <= leadZero && (curDigit == 4'd0);
          digIdx      <= digIdx - 3'd1;
          if (digIdx == 3'd0) state <= (curSep != 7'd0) ? SEP : NEXT;
        end
        SEP: begin
          charRamWrEn <= 1'b1;
          charRamAddr <= cursor;
          charRamData <= curSep;
          cursor      <= nextCursor;
          state       <= NEXT;
        end
        NEXT: begin
          if (fieldIdx == FIELD_W'(NUM_FIELDS - 1)) begin
            state     <= DONE;
            donePulse <= 1'b1;
            busy      <= 1'b0;
          end else begin
            fieldIdx <= fieldIdx + 1'b1;
            dd       <= {BCD_W'(0), valueSnap[fieldIdx + 1'b1]};
            bitCnt   <= '0;
            state    <= CONVERT;
          end
        end
        DONE: begin
          pending <= 1'b0;
          if (pending || trigger) begin
            state <= LATCH;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_numeric_field_writer.sv
// Scoreboard bench for numeric_field_writer: default, wrap-around and auto-tick instances.
module tb_numeric_field_writer;
  localparam int unsigned NF = 4;
  localparam int unsigned VW = 17;
  localparam int unsigned AW = 13;
  localparam int unsigned CELLS = 80 * 60;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [6:0]    data;
  } wr_t;

  logic clock50MHz = 1'b0;
  always #10 clock50MHz = ~clock50MHz;

  logic resetnA, resetnB, updateReqA, updateReqW;
  logic [NF*VW-1:0] fieldValues;
  logic [NF*3-1:0]  fieldDigits;
  logic [NF*7-1:0]  fieldSep;
  logic             suppressZeros;

  logic busyA, doneA, wrEnA, busyW, doneW, wrEnW, busyT, doneT, wrEnT;
  logic [AW-1:0] addrA, addrW, addrT;
  logic [6:0]    dataA, dataW, dataT;

  numeric_field_writer dutA (
    .clock50MHz(clock50MHz), .resetn(resetnA), .fieldValues(fieldValues),
    .fieldDigits(fieldDigits), .fieldSep(fieldSep), .suppressZeros(suppressZeros),
    .updateReq(updateReqA), .busy(busyA), .donePulse(doneA), .charRamWrEn(wrEnA),
    .charRamAddr(addrA), .charRamData(dataA));

  numeric_field_writer #(.BASE_ROW(59), .BASE_COL(78), .TICK_PERIOD(0)) dutW (
    .clock50MHz(clock50MHz), .resetn(resetnB), .fieldValues(fieldValues),
    .fieldDigits(fieldDigits), .fieldSep(fieldSep), .suppressZeros(suppressZeros),
    .updateReq(updateReqW), .busy(busyW), .donePulse(doneW), .charRamWrEn(wrEnW),
    .charRamAddr(addrW), .charRamData(dataW));

  numeric_field_writer #(.TICK_PERIOD(200)) dutT (
    .clock50MHz(clock50MHz), .resetn(resetnB), .fieldValues(fieldValues),
    .fieldDigits(fieldDigits), .fieldSep(fieldSep), .suppressZeros(suppressZeros),
    .updateReq(1'b0), .busy(busyT), .donePulse(doneT), .charRamWrEn(wrEnT),
    .charRamAddr(addrT), .charRamData(dataT));

  int passCount = 0;
  int checkCount = 0;
  int cyc = 0;
  wr_t qA[$];
  wr_t qW[$];
  int writesA = 0, donesA = 0, writesW = 0, donesW = 0;
  int riseT[$];
  logic busyTPrev = 1'b0;

  task automatic checkVal(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clock50MHz) cyc++;

  // Scoreboard pop/compare for the default instance
  always @(negedge clock50MHz) begin
    if (wrEnA) begin
      writesA++;
      if (qA.size() == 0) checkVal("spuriousWriteA queueSize", qA.size(), 1);
      else begin
        wr_t e;
        e = qA.pop_front();
        checkVal("addrA", int'(addrA), int'(e.addr));
        checkVal("dataA", int'(dataA), int'(e.data));
      end
    end
    if (doneA) donesA++;
  end

  always @(negedge clock50MHz) begin
    if (wrEnW) begin
      writesW++;
      if (qW.size() == 0) checkVal("spuriousWriteW queueSize", qW.size(), 1);
      else begin
        wr_t e;
        e = qW.pop_front();
        checkVal("addrW", int'(addrW), int'(e.addr));
        checkVal("dataW", int'(dataW), int'(e.data));
      end
    end
    if (doneW) donesW++;
    if (busyT && !busyTPrev) riseT.push_back(cyc);
    busyTPrev = busyT;
  end

  task automatic setField(input int i, input int value, input int digits, input int sep);
    fieldValues[i*VW +: VW] = VW'(value);
    fieldDigits[i*3 +: 3]   = 3'(digits);
    fieldSep[i*7 +: 7]      = 7'(sep);
  endtask

  task automatic pushStr(input bit toW, input int base, input string s);
    for (int k = 0; k < s.len(); k++) begin
      wr_t e;
      e.addr = AW'((base + k) % CELLS);
      e.data = 7'(s[k]);
      if (toW) qW.push_back(e);
      else qA.push_back(e);
    end
  endtask

  task automatic pulseA();
    @(negedge clock50MHz) updateReqA = 1'b1;
    @(negedge clock50MHz) updateReqA = 1'b0;
  endtask

  task automatic waitDonesA(input int target, input int bound);
    for (int k = 0; k < bound && donesA < target; k++) @(negedge clock50MHz);
    checkVal("doneCountA", donesA, target);
  endtask

  task automatic setMain();
    setField(0, 12, 2, ":");
    setField(1, 34, 2, ":");
    setField(2, 56, 2, ".");
    setField(3, 98765, 5, 0);
    suppressZeros = 1'b0;
  endtask

  initial begin
    int w0, d0, lat;
    resetnA = 1'b0; resetnB = 1'b0; updateReqA = 1'b0; updateReqW = 1'b0;
    fieldValues = '0; fieldDigits = '0; fieldSep = '0; suppressZeros = 1'b0;
    repeat (3) @(posedge clock50MHz);
    #1;
    checkVal("rstWrEn", wrEnA, 0);
    checkVal("rstBusy", busyA, 0);
    checkVal("rstDone", doneA, 0);
    checkVal("rstAddr", int'(addrA), 0);
    checkVal("rstData", int'(dataA), 0);
    checkVal("rstBusyT", busyT, 0);
    @(negedge clock50MHz) begin resetnA = 1'b1; resetnB = 1'b1; end

    // Main pattern with first-write latency
    setMain();
    pushStr(0, 2, "12:34:56.98765");
    w0 = writesA;
    @(negedge clock50MHz) updateReqA = 1'b1;
    @(posedge clock50MHz);
    @(negedge clock50MHz) updateReqA = 1'b0;
    lat = -1;
    for (int k = 1; k < 60; k++) begin
      @(posedge clock50MHz);
      #1;
      if (wrEnA) begin lat = k; break; end
    end
    checkVal("firstWriteLatency", lat, VW + 2);
    checkVal("busyDuringPass", busyA, 1);
    waitDonesA(1, 500);
    repeat (5) @(negedge clock50MHz);
    checkVal("writesMain", writesA - w0, 14);
    checkVal("busyAfterMain", busyA, 0);
    checkVal("queueMain", qA.size(), 0);

    // Suppression on and truncation; inputs scrambled after the snapshot
    setField(0, 7, 3, 0);
    setField(1, 0, 3, 0);
    setField(2, 123, 2, 0);
    setField(3, 131071, 6, 0);
    suppressZeros = 1'b1;
    pushStr(0, 2, "  7  023131071");
    w0 = writesA;
    pulseA();
    @(negedge clock50MHz);
    fieldValues = {NF{VW'($urandom)}};
    fieldDigits = '1;
    fieldSep = {NF{7'd65}};
    suppressZeros = 1'b0;
    waitDonesA(2, 500);
    repeat (5) @(negedge clock50MHz);
    checkVal("writesSuppress", writesA - w0, 14);
    checkVal("queueSuppress", qA.size(), 0);

    // Suppression off, zero digits with separator, clamp of 7 digits to 6
    setField(0, 7, 3, 0);
    setField(1, 0, 3, 0);
    setField(2, 5, 0, ":");
    setField(3, 0, 7, 0);
    suppressZeros = 1'b0;
    pushStr(0, 2, "007000:000000");
    w0 = writesA;
    pulseA();
    waitDonesA(3, 500);
    repeat (5) @(negedge clock50MHz);
    checkVal("writesNoSuppress", writesA - w0, 13);
    checkVal("queueNoSuppress", qA.size(), 0);

    // Three requests during a pass coalesce into one extra pass
    setMain();
    pushStr(0, 2, "12:34:56.98765");
    pushStr(0, 2, "12:34:56.98765");
    w0 = writesA;
    d0 = donesA;
    pulseA();
    repeat (10) @(negedge clock50MHz);
    pulseA();
    repeat (20) @(negedge clock50MHz);
    pulseA();
    repeat (20) @(negedge clock50MHz);
    pulseA();
    waitDonesA(d0 + 2, 1000);
    repeat (300) @(negedge clock50MHz);
    checkVal("coalescePasses", donesA - d0, 2);
    checkVal("coalesceWrites", writesA - w0, 28);
    checkVal("queueCoalesce", qA.size(), 0);

    // Reset during DIGITS aborts the pass
    pushStr(0, 2, "12:34:56.98765");
    w0 = writesA;
    d0 = donesA;
    pulseA();
    for (int k = 0; k < 100; k++) begin
      @(posedge clock50MHz);
      #1;
      if (wrEnA) break;
    end
    resetnA = 1'b0;
    @(posedge clock50MHz);
    #1;
    checkVal("abortWrEn", wrEnA, 0);
    checkVal("abortBusy", busyA, 0);
    @(negedge clock50MHz) resetnA = 1'b1;
    qA.delete();
    repeat (200) @(negedge clock50MHz);
    checkVal("abortDone", donesA - d0, 0);
    checkVal("abortWrites", writesA - w0, 1);

    // Cursor wrap at the bottom-right corner
    setField(0, 1, 1, 0);
    setField(1, 2, 1, 0);
    setField(2, 3, 1, 0);
    setField(3, 4, 1, 0);
    pushStr(1, 59 * 80 + 78, "1234");
    @(negedge clock50MHz) updateReqW = 1'b1;
    @(negedge clock50MHz) updateReqW = 1'b0;
    for (int k = 0; k < 500 && donesW < 1; k++) @(negedge clock50MHz);
    repeat (5) @(negedge clock50MHz);
    checkVal("wrapDone", donesW, 1);
    checkVal("wrapWrites", writesW, 4);
    checkVal("queueWrap", qW.size(), 0);

    // Auto tick spacing
    checkVal("tickPassesSeen", (riseT.size() >= 4) ? 1 : 0, 1);
    if (riseT.size() >= 4) begin
      for (int k = 1; k < 4; k++) checkVal("tickInterval", riseT[k] - riseT[k-1], 200);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
